encoder_round_scheduler: RTL and testbench
==========================================

# encoder_round_scheduler

Round scheduler for the encoder datapath. It sequences the five step units (CP → RO → PE → RE → RC) for a fixed number of rounds using per-step start/finish handshakes and drives the round `iteration` index. A per-step watchdog and an abort input give it a defined error path and recovery. It sits between the encoder top and `encoder_datapath`, and adds timeout/abort supervision and file-index latching.

## Interface
Parameters:
- `NUM_ROUNDS`, default 24: rounds per job.
- `ITER_W`, default 5: width of `iteration`; must satisfy 2^ITER_W ≥ NUM_ROUNDS.
- `TIMEOUT`, default 1023: maximum cycles spent waiting on one step's finish.
- `TO_W`, default 10: watchdog counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  job request; sampled only in IDLE or ERR.
- `abort`  in  1  cancel the current job.
- `file_index_in`  in  10  file index; latched on an accepted start.
- `file_index`  out  10  latched file index, driven to the datapath.
- `cp_start`, `ro_start`, `pe_start`, `re_start`, `rc_start`  out  1 each  one-cycle step start pulses.
- `cp_finish`, `ro_finish`, `pe_finish`, `re_finish`, `rc_finish`  in  1 each  step done.
- `iteration`  out  ITER_W  current round, 0..NUM_ROUNDS-1.
- `step`  out  3  current step code: CP=0, RO=1, PE=2, RE=3, RC=4, none=7.
- `busy`  out  1  high from the first GO state through DONE.
- `finish`  out  1  one-cycle pulse when the job completes.
- `error`  out  1  sticky; set on a watchdog timeout.

## Operation
- States:
  - IDLE
  - CP_GO, CP_WAIT, RO_GO, RO_WAIT, PE_GO, PE_WAIT, RE_GO, RE_WAIT, RC_GO, RC_WAIT
  - DONE
  - ERR
- All outputs are Moore, decoded from registered state. The only exceptions are `iteration`, `file_index` and `error`, which are registers.
- IDLE/ERR with `start`=1:
  - latch `file_index_in`;
  - set `iteration`=0;
  - clear `error`;
  - go to CP_GO.
- X_GO:
  - assert `x_start` for exactly one cycle;
  - clear the watchdog;
  - go to X_WAIT.
- X_WAIT behaviour:
  - If `x_finish` is high, advance to the next step's GO state.
  - If `x_finish` is low, increment the watchdog. When the count reaches TIMEOUT, go to ERR.
- RC_WAIT on `rc_finish`:
  - if `iteration`==NUM_ROUNDS-1, go to DONE;
  - otherwise increment `iteration` and go to CP_GO.
- DONE: `finish`=1 for one cycle, then go to IDLE. `iteration` holds NUM_ROUNDS-1 until the next start.
- ERR:
  - `error`=1, `busy`=0, `step`=7;
  - stays in ERR until `start` or reset.
- Finish inputs are sampled only in the matching WAIT state. Stray finishes from other steps, or finishes during GO states, are ignored.
- `start` while busy is ignored.
- `abort`=1 in any busy state: next state is IDLE, `iteration`=0, no `finish` pulse, `error` unchanged.
- Simultaneous events:
  - `abort` and a finish: abort wins.
  - A finish and watchdog expiry in the same cycle: the finish wins.
  - `abort` in IDLE, ERR or DONE: no effect. DONE still pulses `finish`.

## Timing
- Reset values: state=IDLE, all `*_start`=0, `busy`=0, `finish`=0, `error`=0, `iteration`=0, `step`=7, `file_index`=0, watchdog=0.
- Reset asserted mid-job returns to these values immediately (asynchronously).
- Latency:
  - `start` sampled at edge 0 → `cp_start` high in cycle 1.
  - Minimum of 2 cycles per step when the finish arrives in the first WAIT cycle.
  - With zero-wait steps, `finish` is high in cycle 10·NUM_ROUNDS+1 (241 for the defaults).
- Timeout: ERR is entered on the edge after the watchdog reaches TIMEOUT, i.e. TIMEOUT+1 WAIT cycles after GO.
- `iteration` changes on the edge leaving RC_WAIT. It is stable from each CP_GO through RC_WAIT.

## Structure
- Shared package `encoder_pkg` holds:
  - the state enum;
  - the step-code constants (CP..RC, NONE=7);
  - the default NUM_ROUNDS.
- One sub-module, `step_watchdog`:
  - TO_W-bit counter;
  - inputs `clr` and `en`;
  - output `expired` when the count reaches TIMEOUT.
- The FSM, iteration counter and file-index register live in the top level.

## Test plan
- Reset, then `start` with `file_index_in`=10'h2A5 and finishes returned one cycle after each start → starts pulse in order CP,RO,PE,RE,RC ×24; `iteration` runs 0..23; `finish` in cycle 241; `file_index`=10'h2A5.
- Random 0–20-cycle finish delays → step order unchanged; exactly one `finish`; `busy` is never low mid-job.
- TIMEOUT=15 and `pe_finish` withheld at iteration 3 → ERR 16 cycles after `pe_start`; `error`=1; `busy`=0; a new `start` clears `error` and restarts at iteration 0.
- `abort` at iteration 7 in RO_WAIT, same cycle as `ro_finish` → IDLE next cycle, `iteration`=0, no `finish`, no `pe_start`.
- Stray `rc_finish` during CP_WAIT, plus a second `start` while busy → both ignored; the sequence completes normally.
- Reset asserted in RE_WAIT at iteration 12 → all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/encoder_pkg.sv
// encoder_pkg
// Shared definitions for the encoder round scheduler:
//   - schedState_e : scheduler FSM state encoding
//   - STEP_*       : step codes driven on the 'step' output (CP..RC, NONE)
//   - NUM_ROUNDS_DEFAULT : rounds per job when the top is not overridden
package encoder_pkg;

  localparam int NUM_ROUNDS_DEFAULT = 24;

  localparam logic [2:0] STEP_CP   = 3'd0;
  localparam logic [2:0] STEP_RO   = 3'd1;
  localparam logic [2:0] STEP_PE   = 3'd2;
  localparam logic [2:0] STEP_RE   = 3'd3;
  localparam logic [2:0] STEP_RC   = 3'd4;
  localparam logic [2:0] STEP_NONE = 3'd7;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CP_GO,
    ST_CP_WAIT,
    ST_RO_GO,
    ST_RO_WAIT,
    ST_PE_GO,
    ST_PE_WAIT,
    ST_RE_GO,
    ST_RE_WAIT,
    ST_RC_GO,
    ST_RC_WAIT,
    ST_DONE,
    ST_ERR
  } schedState_e;

endpackage

// File: rtl/step_watchdog.sv
// step_watchdog
// Counts cycles spent waiting on a single step's finish and flags when the
// count reaches TIMEOUT.
// Ports:
//   clk     in  clock, rising edge
//   rst     in  asynchronous active-low reset
//   clr     in  restart the count at zero (priority over en)
//   en      in  advance the count by one
//   expired out count has reached TIMEOUT
module step_watchdog #(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count_q, count_d;

  assign expired = (count_q == TO_W'(TIMEOUT));

  // Next count: clear wins, and the count parks at TIMEOUT so it can never
  // wrap back under the limit while nobody is watching it.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/encoder_round_scheduler.sv
// encoder_round_scheduler
// Sequences the five encoder step units (CP -> RO -> PE -> RE -> RC) for
// NUM_ROUNDS rounds using start/finish handshakes, with a per-step watchdog
// and an abort path.
// Ports:
//   clk, rst                  clock / asynchronous active-low reset
//   start, abort              job request / cancel current job
//   file_index_in, file_index file index in / latched copy to the datapath
//   x_start (x=cp,ro,pe,re,rc) one-cycle step start pulses
//   x_finish                  step done inputs
//   iteration                 current round 0..NUM_ROUNDS-1
//   step                      current step code (7 = none)
//   busy, finish, error       job active / job complete pulse / sticky timeout
module encoder_round_scheduler
  import encoder_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT,
  parameter int ITER_W     = 5,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [9:0]        file_index_in,
  output logic [9:0]        file_index,
  output logic              cp_start,
  output logic              ro_start,
  output logic              pe_start,
  output logic              re_start,
  output logic              rc_start,
  input  logic              cp_finish,
  input  logic              ro_finish,
  input  logic              pe_finish,
  input  logic              re_finish,
  input  logic              rc_finish,
  output logic [ITER_W-1:0] iteration,
  output logic [2:0]        step,
  output logic              busy,
  output logic              finish,
  output logic              error
);

  schedState_e state_q, state_d;
  schedState_e nextGo;
  logic [ITER_W-1:0] iteration_q, iteration_d;
  logic [9:0] fileIndex_q, fileIndex_d;
  logic error_q, error_d;
  logic wdClr, wdEn, wdExpired;
  logic stepFinish;
  logic inJob;
  logic lastRound;

  assign inJob = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
  assign lastRound = (iteration_q == ITER_W'(NUM_ROUNDS - 1));

  step_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wdClr),
    .en      (wdEn),
    .expired (wdExpired)
  );

  // Select the one finish input that matters in the current WAIT state and
  // the GO state that follows it; finishes from any other step are never
  // looked at, which is what makes stray finishes harmless.
  always_comb begin
    stepFinish = 1'b0;
    nextGo     = ST_IDLE;
    case (state_q)
      ST_CP_WAIT: begin stepFinish = cp_finish; nextGo = ST_RO_GO; end
      ST_RO_WAIT: begin stepFinish = ro_finish; nextGo = ST_PE_GO; end
      ST_PE_WAIT: begin stepFinish = pe_finish; nextGo = ST_RE_GO; end
      ST_RE_WAIT: begin stepFinish = re_finish; nextGo = ST_RC_GO; end
      ST_RC_WAIT: begin stepFinish = rc_finish; nextGo = ST_CP_GO; end
      default: ;
    endcase
  end

  // Next-state logic. Inside a WAIT state the finish is checked before the
  // watchdog so a finish arriving on the expiry cycle still advances. Abort
  // is applied last so it overrides everything while a job is in flight,
  // but leaves the sticky error flag alone.
  always_comb begin
    state_d     = state_q;
    iteration_d = iteration_q;
    fileIndex_d = fileIndex_q;
    error_d     = error_q;
    wdClr       = 1'b0;
    wdEn        = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          fileIndex_d = file_index_in;
          iteration_d = '0;
          error_d     = 1'b0;
          state_d     = ST_CP_GO;
        end
      end
      ST_CP_GO: begin wdClr = 1'b1; state_d = ST_CP_WAIT; end
      ST_RO_GO: begin wdClr = 1'b1; state_d = ST_RO_WAIT; end
      ST_PE_GO: begin wdClr = 1'b1; state_d = ST_PE_WAIT; end
      ST_RE_GO: begin wdClr = 1'b1; state_d = ST_RE_WAIT; end
      ST_RC_GO: begin wdClr = 1'b1; state_d = ST_RC_WAIT; end
      ST_CP_WAIT, ST_RO_WAIT, ST_PE_WAIT, ST_RE_WAIT, ST_RC_WAIT: begin
        if (stepFinish) begin
          if (state_q == ST_RC_WAIT) begin
            if (lastRound) begin
              state_d = ST_DONE;
            end else begin
              iteration_d = iteration_q + 1'b1;
              state_d     = ST_CP_GO;
            end
          end else begin
            state_d = nextGo;
          end
        end else if (wdExpired) begin
          error_d = 1'b1;
          state_d = ST_ERR;
        end else begin
          wdEn = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && inJob) begin
      state_d     = ST_IDLE;
      iteration_d = '0;
      error_d     = error_q;
    end
  end

  // Moore output decode: every handshake and status output comes straight
  // from the registered state.
  always_comb begin
    cp_start = 1'b0;
    ro_start = 1'b0;
    pe_start = 1'b0;
    re_start = 1'b0;
    rc_start = 1'b0;
    step     = STEP_NONE;
    busy     = 1'b0;
    finish   = 1'b0;
    case (state_q)
      ST_CP_GO:   begin cp_start = 1'b1; step = STEP_CP; busy = 1'b1; end
      ST_CP_WAIT: begin step = STEP_CP; busy = 1'b1; end
      ST_RO_GO:   begin ro_start = 1'b1; step = STEP_RO; busy = 1'b1; end
      ST_RO_WAIT: begin step = STEP_RO; busy = 1'b1; end
      ST_PE_GO:   begin pe_start = 1'b1; step = STEP_PE; busy = 1'b1; end
      ST_PE_WAIT: begin step = STEP_PE; busy = 1'b1; end
      ST_RE_GO:   begin re_start = 1'b1; step = STEP_RE; busy = 1'b1; end
      ST_RE_WAIT: begin step = STEP_RE; busy = 1'b1; end
      ST_RC_GO:   begin rc_start = 1'b1; step = STEP_RC; busy = 1'b1; end
      ST_RC_WAIT: begin step = STEP_RC; busy = 1'b1; end
      ST_DONE:    begin busy = 1'b1; finish = 1'b1; end
      default: ;
    endcase
  end

  // State, round counter, file index and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      iteration_q <= '0;
      fileIndex_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      iteration_q <= iteration_d;
      fileIndex_q <= fileIndex_d;
      error_q     <= error_d;
    end
  end

  assign iteration  = iteration_q;
  assign file_index = fileIndex_q;
  assign error      = error_q;

endmodule

// File: tb/tb_encoder_round_scheduler.sv
// tb_encoder_round_scheduler
// Drives whole jobs through the round scheduler, acting as the five step
// units with random finish delays, and checks every cycle against the
// expected round/step protocol.
module tb_encoder_round_scheduler;

  localparam int NR  = 24;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [9:0] file_index_in = '0;
  logic [9:0] file_index;
  logic [4:0] finishVec = '0;
  logic       cp_start, ro_start, pe_start, re_start, rc_start;
  logic [4:0] startVec;
  logic [4:0] iteration;
  logic [2:0] step;
  logic       busy, finish, error;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int finishCount = 0;

  assign startVec = {rc_start, re_start, pe_start, ro_start, cp_start};

  encoder_round_scheduler #(
    .NUM_ROUNDS (NR),
    .ITER_W     (5),
    .TIMEOUT    (TMO),
    .TO_W       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .file_index_in (file_index_in),
    .file_index    (file_index),
    .cp_start      (cp_start),
    .ro_start      (ro_start),
    .pe_start      (pe_start),
    .re_start      (re_start),
    .rc_start      (rc_start),
    .cp_finish     (finishVec[0]),
    .ro_finish     (finishVec[1]),
    .pe_finish     (finishVec[2]),
    .re_finish     (finishVec[3]),
    .rc_finish     (finishVec[4]),
    .iteration     (iteration),
    .step          (step),
    .busy          (busy),
    .finish        (finish),
    .error         (error)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Count job-complete pulses mid-cycle so each job can check for exactly one.
  always @(negedge clk) begin
    if (finish === 1'b1) finishCount++;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Run one job acting as the step units.
  //   maxDelay    : finish delay drawn from 0..maxDelay (0 = zero-wait job)
  //   stallRound  : round whose PE finish is withheld (-1 = none)
  //   abortRound  : round where abort meets ro_finish in RO_WAIT (-1 = none)
  //   strayRound  : round with stray finishes and a busy start (-1 = none)
  //   resetRound  : round where reset hits in RE_WAIT (-1 = none)
  //   abortInDone : raise abort during the DONE cycle
  task automatic applyStimulus(input logic [9:0] fidx, input int maxDelay, input int stallRound,
                               input int abortRound, input int strayRound, input int resetRound,
                               input bit abortInDone);
    int d;
    int w;
    int c0;
    int fc0;
    bit ended;
    bit stepDone;
    logic [15:0] expVec;

    fc0 = finishCount;
    ended = 1'b0;
    start = 1'b1;
    file_index_in = fidx;
    c0 = cycle;
    tick();
    start = 1'b0;
    file_index_in = 10'($urandom);
    checkOutput("error_cleared", error, 0);
    checkOutput("file_index_latched", file_index, fidx);

    for (int r = 0; r < NR && !ended; r++) begin
      for (int s = 0; s < 5 && !ended; s++) begin
        // GO cycle: exactly this step's start pulse.
        expVec = {5'(1 << s), 1'b1, 1'b0, 1'b0, 3'(s), 5'(r)};
        checkOutput("go_outputs", {startVec, busy, finish, error, step, iteration}, expVec);

        if (r == strayRound && s == 0) begin
          start = 1'b1;
          finishVec = 5'b11111;
          file_index_in = 10'($urandom);
        end

        d = (maxDelay > 0) ? $urandom_range(0, maxDelay) : 0;
        if (maxDelay > 0 && r == 5 && s == 1) d = TMO;
        if (r == stallRound && s == 2) d = 10000;
        if (r == resetRound && s == 3) d = 5;

        tick();
        start = 1'b0;
        finishVec = '0;

        w = 0;
        stepDone = 1'b0;
        while (!stepDone && !ended) begin
          w++;
          expVec = {5'b0, 1'b1, 1'b0, 1'b0, 3'(s), 5'(r)};
          checkOutput("wait_outputs", {startVec, busy, finish, error, step, iteration}, expVec);

          if (r == resetRound && s == 3 && w == 2) begin
            #2 rst = 1'b0;
            #1;
            checkOutput("reset_async", {startVec, busy, finish, error, step, iteration, file_index},
                        {5'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'd0, 10'd0});
            tick();
            rst = 1'b1;
            tick();
            checkOutput("reset_release_idle", {startVec, busy, step, iteration}, {5'b0, 1'b0, 3'd7, 5'd0});
            ended = 1'b1;
          end else if (r == abortRound && s == 1 && w == 1) begin
            abort = 1'b1;
            finishVec = 5'b00010;
            tick();
            abort = 1'b0;
            finishVec = '0;
            checkOutput("abort_to_idle", {startVec, busy, finish, error, step, iteration},
                        {5'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'd0});
            for (int k = 0; k < 4; k++) begin
              tick();
              checkOutput("abort_quiet", {startVec, finish, busy}, 0);
            end
            ended = 1'b1;
          end else begin
            finishVec = ((r == strayRound && s == 0 && w == 1) ? 5'b10000 : 5'b00000) |
                        ((w == d + 1) ? 5'(1 << s) : 5'b00000);
            tick();
            finishVec = '0;
            if (w == d + 1) begin
              stepDone = 1'b1;
            end else if (w == TMO + 1) begin
              checkOutput("timeout_err", {startVec, busy, finish, error, step}, {5'b0, 1'b0, 1'b0, 1'b1, 3'd7});
              tick();
              checkOutput("err_sticky", {busy, error, step}, {1'b0, 1'b1, 3'd7});
              ended = 1'b1;
            end
          end
        end
      end
    end

    if (!ended) begin
      checkOutput("done_outputs", {startVec, busy, finish, step, iteration}, {5'b0, 1'b1, 1'b1, 3'd7, 5'(NR - 1)});
      if (maxDelay == 0) checkOutput("done_cycle", cycle - c0, 10 * NR + 1);
      if (abortInDone) abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("idle_after_done", {busy, finish, error, step, iteration, file_index},
                  {1'b0, 1'b0, 1'b0, 3'd7, 5'(NR - 1), fidx});
    end
    checkOutput("finish_pulses", finishCount - fc0, ended ? 0 : 1);
  endtask

  initial begin
    tick();
    tick();
    checkOutput("reset_values", {startVec, busy, finish, error, step, iteration, file_index},
                {5'b0, 1'b0, 1'b0, 1'b0, 3'd7, 5'd0, 10'd0});
    rst = 1'b1;
    tick();
    checkOutput("idle_after_reset", {startVec, busy, finish, error, step},
                {5'b0, 1'b0, 1'b0, 1'b0, 3'd7});

    // Zero-wait job with file index 10'h2A5.
    applyStimulus(10'h2A5, 0, -1, -1, -1, -1, 1'b0);
    // Random delays up to the watchdog limit; abort during DONE is ignored.
    applyStimulus(10'($urandom), TMO, -1, -1, -1, -1, 1'b1);
    // PE finish withheld in round 3: timeout into ERR.
    applyStimulus(10'($urandom), TMO, 3, -1, -1, -1, 1'b0);
    // Restart from ERR with stray finishes and a start while busy.
    applyStimulus(10'($urandom), 6, -1, -1, 2, -1, 1'b0);
    // Abort colliding with ro_finish in round 7.
    applyStimulus(10'($urandom), 4, -1, 7, -1, -1, 1'b0);

    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_in_idle", {startVec, busy, step}, {5'b0, 1'b0, 3'd7});

    // Asynchronous reset in RE_WAIT of round 12, then a clean recovery job.
    applyStimulus(10'($urandom), 4, -1, -1, -1, 12, 1'b0);
    applyStimulus(10'($urandom), 3, -1, -1, -1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
